ram_lane_sweep: RTL

- Parametrised single-port synchronous RAM. It generalises the fixed-size composed RAM cells to arbitrary word width and depth.
- Adds per-lane write masking, a registered read with a valid strobe, and a hardware zero-sweep state machine that initialises memory after reset or on request.
- Sits wherever the datapath needs a small scratch/register store with a known-zero start state.

---
 rtl/ram_lane_sweep.sv | 107 ++++++++++
 1 files changed

// File: rtl/ram_lane_sweep.sv
// rtl/ram_lane_sweep.sv - single-port lane-masked RAM with registered read and hardware zero-sweep
module ram_lane_sweep #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LANE  = 4,
    localparam int LANES = WIDTH / LANE,
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             r_w,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    input  logic [LANES-1:0] lane_we,
    input  logic             zero,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             ready
);

    typedef enum logic {INIT, IDLE} state_t;

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t          state, state_d;
    logic [AW-1:0]   ptr, ptr_d;
    logic            in_range;
    logic            sweep_we;
    logic            rd_go;
    logic            wr_go;
    logic [WIDTH-1:0] mem [DEPTH];

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign in_range = ({1'b0, addr} < DEPTH_V);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        case (state)
            INIT: begin
                if (zero) begin
                    ptr_d = '0;
                end else if (ptr == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr + AW'(1);
                end
            end
            IDLE: begin
                if (zero) begin
                    state_d = INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // A zero request in IDLE wins over any access presented in the same cycle.
    always_comb begin
        ready    = (state == IDLE);
        sweep_we = (state == INIT);
        rd_go    = (state == IDLE) && en && !zero && r_w;
        wr_go    = (state == IDLE) && en && !zero && !r_w && in_range;
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[ptr] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    mem[addr][i*LANE +: LANE] <= din[i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_go;
            if (rd_go) begin
                dout <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule
